numbers_concat_arb: RTL and testbench

//  Shares one concat/replicate pack unit between two requesters (req0, req1).

---
 rtl/numbers_concat_arb.sv | 128 ++++++++++++
 tb/tb_numbers_concat_arb.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/numbers_concat_arb.sv
// Round-robin arbiter in front of a shared concat/replicate byte packer.
// The packed result sits in a single-entry output register with a valid/ready handshake.
module numbers_concat_arb #(
  parameter logic [1:0] PAD   = 2'b00,
  parameter int         CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [3:0]       req0_a,
  input  logic [1:0]       req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [3:0]       req1_a,
  input  logic [1:0]       req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic             res_src,
  output logic             res_err,
  output logic [CNT_W-1:0] res_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic             rr_reg, rr_next;
  logic [7:0]       data_reg, data_next;
  logic             src_reg, src_next;
  logic             err_reg, err_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic [1:0][1:0] op_arr;
  logic [1:0][3:0] a_arr;
  logic [1:0][1:0] b_arr;
  logic [1:0][8:0] pack_res;

  logic can_accept, grant0, grant1, acc0, acc1, consume, sel;

  // Result is {err, data}; illegal op packs to zero with the error flag set.
  function automatic logic [8:0] pack(input logic [1:0] op, input logic [3:0] a,
                                      input logic [1:0] b);
    logic [8:0] r;
    r = 9'h000;
    case (op)
      2'b00:   r = {1'b0, a, b, PAD};
      2'b01:   r = {1'b0, 4'b0000, a};
      2'b10:   r = {1'b0, 2'b00, b, b, b};
      default: r = {1'b1, 8'h00};
    endcase
    return r;
  endfunction

  assign op_arr[0] = req0_op;
  assign op_arr[1] = req1_op;
  assign a_arr[0]  = req0_a;
  assign a_arr[1]  = req1_a;
  assign b_arr[0]  = req0_b;
  assign b_arr[1]  = req1_b;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_pack
      assign pack_res[gi] = pack(op_arr[gi], a_arr[gi], b_arr[gi]);
    end
  endgenerate

  always_comb begin
    can_accept = (state_reg == EMPTY) | res_ready;
    // rr_reg == 0 favours req0 when both requesters are valid.
    grant0     = req0_valid & (~req1_valid | ~rr_reg);
    grant1     = req1_valid & (~req0_valid | rr_reg);
    req0_ready = grant0 & can_accept & ~rst;
    req1_ready = grant1 & can_accept & ~rst;
    acc0       = req0_valid & req0_ready;
    acc1       = req1_valid & req1_ready;
    consume    = (state_reg == FULL) & res_ready;
    sel        = acc1;

    state_next = state_reg;
    rr_next    = rr_reg;
    data_next  = data_reg;
    src_next   = src_reg;
    err_next   = err_reg;
    count_next = count_reg;

    if (acc0 | acc1) begin
      state_next = FULL;
      rr_next    = acc0;
      data_next  = pack_res[sel][7:0];
      src_next   = sel;
      err_next   = pack_res[sel][8];
    end else if (consume) begin
      state_next = EMPTY;
    end

    if (consume) begin
      count_next = count_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= EMPTY;
      rr_reg    <= 1'b0;
      data_reg  <= 8'h00;
      src_reg   <= 1'b0;
      err_reg   <= 1'b0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      rr_reg    <= rr_next;
      data_reg  <= data_next;
      src_reg   <= src_next;
      err_reg   <= err_next;
      count_reg <= count_next;
    end
  end

  assign res_valid = (state_reg == FULL);
  assign res_data  = data_reg;
  assign res_src   = src_reg;
  assign res_err   = err_reg;
  assign res_count = count_reg;

endmodule

// File: tb/tb_numbers_concat_arb.sv
// Directed bench for numbers_concat_arb: the driver issues requests with hand-computed
// results, a negedge monitor tracks the handshake and checks results from a scoreboard queue.
module tb_numbers_concat_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [1:0] req0_op = 2'b00, req1_op = 2'b00;
  logic [3:0] req0_a = 4'h0, req1_a = 4'h0;
  logic [1:0] req0_b = 2'b00, req1_b = 2'b00;
  logic       res_valid, res_ready = 1'b0;
  logic [7:0] res_data;
  logic       res_src, res_err;
  logic [7:0] res_count;

  numbers_concat_arb #(.PAD(2'b00), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_src(res_src), .res_err(res_err), .res_count(res_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Hand-computed result for whatever each requester currently presents.
  logic [7:0] exp0_data = 8'h00, exp1_data = 8'h00;
  logic       exp0_err = 1'b0, exp1_err = 1'b0;

  logic [9:0] sb_q[$];
  logic       m_full = 1'b0;
  logic       m_rr = 1'b0;
  logic [7:0] m_count = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor/scoreboard: compares the held result, then applies the coming edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic er0, er1;
      er0 = !rst && req0_valid && (!req1_valid || !m_rr) && (!m_full || res_ready);
      er1 = !rst && req1_valid && (!req0_valid ||  m_rr) && (!m_full || res_ready);
      check("mon_ready0", 32'(req0_ready), 32'(er0));
      check("mon_ready1", 32'(req1_ready), 32'(er1));
      check("mon_valid", 32'(res_valid), 32'(m_full));
      check("mon_count", 32'(res_count), 32'(m_count));
      if (m_full) begin
        if (sb_q.size() == 0) begin
          check("mon_queue_empty", 32'(1), 32'(0));
        end else begin
          check("mon_data", 32'(res_data), 32'(sb_q[0][7:0]));
          check("mon_src",  32'(res_src),  32'(sb_q[0][8]));
          check("mon_err",  32'(res_err),  32'(sb_q[0][9]));
        end
      end
      if (rst) begin
        sb_q.delete();
        m_full  = 1'b0;
        m_rr    = 1'b0;
        m_count = 8'h00;
      end else begin
        if (m_full && res_ready) begin
          if (sb_q.size() != 0) void'(sb_q.pop_front());
          m_count = m_count + 8'd1;
        end
        if (er0) begin
          sb_q.push_back({exp0_err, 1'b0, exp0_data});
          m_rr = 1'b1;
        end else if (er1) begin
          sb_q.push_back({exp1_err, 1'b1, exp1_data});
          m_rr = 1'b0;
        end
        m_full = er0 || er1 || (m_full && !res_ready);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic set_req(input bit n, input logic [1:0] op, input logic [3:0] a,
                         input logic [1:0] b, input logic [7:0] exp, input logic e);
    if (n == 1'b0) begin
      req0_op = op; req0_a = a; req0_b = b; exp0_data = exp; exp0_err = e;
      req0_valid = 1'b1;
    end else begin
      req1_op = op; req1_a = a; req1_b = b; exp1_data = exp; exp1_err = e;
      req1_valid = 1'b1;
    end
  endtask

  // Single request, held until accepted, with a bounded wait.
  task automatic send(input bit n, input logic [1:0] op, input logic [3:0] a,
                      input logic [1:0] b, input logic [7:0] exp, input logic e);
    bit got;
    got = 1'b0;
    set_req(n, op, a, b, exp, e);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((n == 1'b0 && req0_ready) || (n == 1'b1 && req1_ready)) begin
        got = 1'b1;
        break;
      end
    end
    cyc();
    if (n == 1'b0) req0_valid = 1'b0; else req1_valid = 1'b0;
    if (!got) check("send_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    cyc();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_valid", 32'(res_valid), 32'(0));
    check("rst_data",  32'(res_data),  32'(8'h00));
    check("rst_src",   32'(res_src),   32'(0));
    check("rst_err",   32'(res_err),   32'(0));
    check("rst_count", 32'(res_count), 32'(0));
    cyc();

    // 1: CAT a=A b=3
    res_ready = 1'b1;
    send(1'b0, 2'b00, 4'hA, 2'b11, 8'hAC, 1'b0);
    @(negedge clk);
    check("t1_valid", 32'(res_valid), 32'(1));
    check("t1_data",  32'(res_data),  32'(8'hAC));
    check("t1_src",   32'(res_src),   32'(0));
    check("t1_err",   32'(res_err),   32'(0));
    cyc();

    // 2: remaining ops
    send(1'b0, 2'b01, 4'h5, 2'b10, 8'h05, 1'b0);
    send(1'b1, 2'b10, 4'h9, 2'b10, 8'h2A, 1'b0);
    send(1'b1, 2'b11, 4'hF, 2'b11, 8'h00, 1'b1);
    @(negedge clk);
    check("t2_illegal_err",  32'(res_err),  32'(1));
    check("t2_illegal_data", 32'(res_data), 32'(8'h00));
    cyc();
    send(1'b1, 2'b00, 4'hF, 2'b11, 8'hFC, 1'b0);
    send(1'b0, 2'b01, 4'hF, 2'b00, 8'h0F, 1'b0);
    send(1'b1, 2'b10, 4'h0, 2'b01, 8'h15, 1'b0);
    cyc();

    // 3: both valid continuously, alternating grants, one result per cycle
    do_reset();
    res_ready = 1'b1;
    set_req(1'b0, 2'b00, 4'h1, 2'b00, 8'h10, 1'b0);
    set_req(1'b1, 2'b10, 4'h0, 2'b01, 8'h15, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        check("t3_valid", 32'(res_valid), 32'(1));
        check("t3_src",   32'(res_src),   32'((k - 1) % 2));
      end
    end
    cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cyc();

    // 4: stall for 3 cycles while full
    do_reset();
    res_ready = 1'b0;
    set_req(1'b0, 2'b00, 4'h3, 2'b01, 8'h34, 1'b0);
    set_req(1'b1, 2'b01, 4'h7, 2'b00, 8'h07, 1'b0);
    @(negedge clk);
    check("t4_first_ready0", 32'(req0_ready), 32'(1));
    check("t4_first_ready1", 32'(req1_ready), 32'(0));
    cyc();
    req0_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t4_stall_valid",  32'(res_valid),  32'(1));
      check("t4_stall_data",   32'(res_data),   32'(8'h34));
      check("t4_stall_ready0", 32'(req0_ready), 32'(0));
      check("t4_stall_ready1", 32'(req1_ready), 32'(0));
    end
    cyc();
    res_ready = 1'b1;
    @(negedge clk);
    check("t4_release_data",   32'(res_data),   32'(8'h34));
    check("t4_release_ready1", 32'(req1_ready), 32'(1));
    cyc();
    req1_valid = 1'b0;
    @(negedge clk);
    check("t4_next_data", 32'(res_data), 32'(8'h07));
    check("t4_next_src",  32'(res_src),  32'(1));
    cyc();
    cyc();

    // 5: reset while full with both requesters valid
    do_reset();
    res_ready = 1'b0;
    set_req(1'b0, 2'b10, 4'h0, 2'b11, 8'h3F, 1'b0);
    set_req(1'b1, 2'b00, 4'h5, 2'b10, 8'h58, 1'b0);
    @(negedge clk);
    check("t5_ready0", 32'(req0_ready), 32'(1));
    cyc();
    rst = 1'b1;
    @(negedge clk);
    check("t5_inrst_ready0", 32'(req0_ready), 32'(0));
    check("t5_inrst_ready1", 32'(req1_ready), 32'(0));
    check("t5_full",         32'(res_valid),  32'(1));
    cyc();
    rst = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    check("t5_post_valid",  32'(res_valid),  32'(0));
    check("t5_post_count",  32'(res_count),  32'(0));
    check("t5_post_data",   32'(res_data),   32'(8'h00));
    check("t5_post_ready0", 32'(req0_ready), 32'(1));
    check("t5_post_ready1", 32'(req1_ready), 32'(0));
    cyc();
    req0_valid = 1'b0;
    @(negedge clk);
    check("t5_r1_ready1", 32'(req1_ready), 32'(1));
    check("t5_r1_data",   32'(res_data),   32'(8'h3F));
    check("t5_r1_src",    32'(res_src),    32'(0));
    cyc();
    req1_valid = 1'b0;
    @(negedge clk);
    check("t5_r2_data", 32'(res_data), 32'(8'h58));
    check("t5_r2_src",  32'(res_src),  32'(1));
    cyc();
    cyc();

    // 6: 256 consumes wrap the counter
    do_reset();
    res_ready = 1'b1;
    set_req(1'b0, 2'b01, 4'h1, 2'b00, 8'h01, 1'b0);
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      check("t6_ready0", 32'(req0_ready), 32'(1));
    end
    cyc();
    req0_valid = 1'b0;
    @(negedge clk);
    check("t6_count_255", 32'(res_count), 32'(255));
    @(negedge clk);
    check("t6_count_wrap", 32'(res_count), 32'(0));
    check("t6_empty",      32'(res_valid), 32'(0));
    cyc();

    chk_en = 1'b0;
    if (sb_q.size() != 0) check("sb_leftover", 32'(sb_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
